// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the ALU issue/writeback sequencer.
// Opcode/cond field values match the instruction word layout consumed by alu_issue_ctrl.
package alu_ctrl_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_REG_AW = 3;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;

    localparam logic [1:0] CND_ALW = 2'b00;
    localparam logic [1:0] CND_C   = 2'b01;
    localparam logic [1:0] CND_Z   = 2'b10;
    localparam logic [1:0] CND_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic [ALU_DATA_W-1:0] sext6(input logic [5:0] imm6);
        return {{(ALU_DATA_W-6){imm6[5]}}, imm6};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational decode of opcode/cond against the architectural flags.
// ADI ignores its cond bits (they overlap imm6) and always executes.
module cond_eval
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] cond_i,
    input  logic [3:0] opcode_i,
    input  logic       flag_c_i,
    input  logic       flag_z_i,
    output logic       exec_en_o,
    output logic       illegal_o
);

    always_comb begin
        exec_en_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_NDU: begin
                case (cond_i)
                    CND_ALW: exec_en_o = 1'b1;
                    CND_C:   exec_en_o = flag_c_i;
                    CND_Z:   exec_en_o = flag_z_i;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADI:  exec_en_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer in front of an external combinational ALU: reads operands,
// drives the ALU, then conditionally writes the result back and updates the C/Z flags.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready
// are both high; instr_ready is high only in IDLE, and the source must hold instr until then.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_c,
    output logic              flag_z,
    output logic              done,
    output logic              skipped,
    output logic              illegal,
    output state_t            dbg_state_o
);

    state_t              state_q;
    logic [15:0]         instr_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic                alu_op_q;
    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_waddr_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic                flag_c_q;
    logic                flag_z_q;
    logic                done_q;
    logic                skipped_q;
    logic                illegal_q;

    logic [3:0]          opcode_q;
    logic                is_adi;
    logic [2:0]          dest_d;
    logic [DATA_W-1:0]   imm_ext;
    logic [15:0]         cond_src;
    logic                cond_exec_en;
    logic                cond_illegal;

    assign opcode_q = instr_q[15:12];
    assign is_adi   = (opcode_q == OP_ADI);
    assign dest_d   = is_adi ? instr_q[8:6] : instr_q[5:3];
    assign imm_ext  = DATA_W'(sext6(instr_q[5:0]));

    // In IDLE the decoder looks at the offered word (legality); afterwards at the latched one.
    assign cond_src = (state_q == IDLE) ? instr : instr_q;

    cond_eval u_cond_eval (
        .cond_i    (cond_src[1:0]),
        .opcode_i  (cond_src[15:12]),
        .flag_c_i  (flag_c_q),
        .flag_z_i  (flag_z_q),
        .exec_en_o (cond_exec_en),
        .illegal_o (cond_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            done_q     <= 1'b0;
            skipped_q  <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            skipped_q <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        if (cond_illegal) begin
                            state_q   <= WB;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    alu_a_q  <= rf_ra_data;
                    alu_b_q  <= is_adi ? imm_ext : rf_rb_data;
                    alu_op_q <= (opcode_q == OP_NDU);
                    state_q  <= EXEC;
                end
                EXEC: begin
                    // Result, write strobe and flags all land together in the WB cycle; the
                    // condition uses flags as left by the previous instruction.
                    state_q <= WB;
                    done_q  <= 1'b1;
                    if (cond_exec_en) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= REG_AW'(dest_d);
                        rf_wdata_q <= alu_res;
                        flag_z_q   <= (alu_res == '0);
                        if (!alu_op_q) begin
                            flag_c_q <= alu_cout;
                        end
                    end else begin
                        skipped_q <= 1'b1;
                    end
                end
                WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign rf_ra_addr  = REG_AW'(instr_q[11:9]);
    assign rf_rb_addr  = REG_AW'(instr_q[8:6]);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign done        = done_q;
    assign skipped     = skipped_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU environment models, a hand-written
// vector table, directed multi-cycle sequences and random instructions vs a reference model.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  rf_ra_addr, rf_rb_addr;
  logic [15:0] rf_ra_data, rf_rb_data;
  logic [15:0] alu_a, alu_b, alu_res;
  logic        alu_op, alu_cout;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        flag_c, flag_z, done, skipped, illegal;
  state_t      dbg_state;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res), .alu_cout(alu_cout), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flag_c(flag_c), .flag_z(flag_z),
    .done(done), .skipped(skipped), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // environment: register file with a preload port, combinational ALU
  logic [15:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [16:0] alu_sum;

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_res    = alu_op ? ~(alu_a & alu_b) : alu_sum[15:0];
  assign alu_cout   = alu_sum[16];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  // reference state
  logic [15:0] ref_rf [8];
  logic        ref_c = 1'b0;
  logic        ref_z = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          lat;
    logic        ill;
    logic        skip;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        c;
    logic        z;
  } exp_t;

  typedef struct {
    int          lat;
    int          we_cnt;
    logic        ill;
    logic        skip;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        c;
    logic        z;
    logic        rdy;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    bit          preset;
    logic [15:0] ra_v;
    logic [15:0] rb_v;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [2:0] rc,
                                      input logic [1:0] cnd);
    return {op, ra, rb, rc, 1'b0, cnd};
  endfunction

  function automatic logic [15:0] enc_adi(input logic [2:0] ra, input logic [2:0] rb,
                                          input logic [5:0] imm);
    return {4'b0001, ra, rb, imm};
  endfunction

  function automatic exp_t mk(input int lat, input logic ill, input logic skip, input logic we,
                              input logic [2:0] wa, input logic [15:0] wd,
                              input logic c, input logic z);
    exp_t e;
    e.lat = lat; e.ill = ill; e.skip = skip; e.we = we;
    e.waddr = wa; e.wdata = wd; e.c = c; e.z = z;
    return e;
  endfunction

  // Reference model: architectural effect of one instruction from the rules, plain arithmetic.
  task automatic predict(input logic [15:0] ins, output exp_t e);
    logic [3:0]  op;
    logic [1:0]  cnd;
    logic [15:0] a, b, res;
    int          sum;
    bit          go;
    op = ins[15:12];
    cnd = ins[1:0];
    e = mk(3, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, ref_c, ref_z);
    go = 1'b0;
    if (op == 4'd1) go = 1'b1;
    else if (op == 4'd0 || op == 4'd2) begin
      if (cnd == 2'd0) go = 1'b1;
      else if (cnd == 2'd1) go = ref_c;
      else if (cnd == 2'd2) go = ref_z;
      else e.ill = 1'b1;
    end else e.ill = 1'b1;
    if (e.ill) e.lat = 1;
    else if (!go) e.skip = 1'b1;
    else begin
      a = ref_rf[ins[11:9]];
      if (op == 4'd1) b = 16'($signed(ins[5:0]));
      else b = ref_rf[ins[8:6]];
      if (op == 4'd2) res = ~(a & b);
      else begin
        sum = int'(a) + int'(b);
        res = sum[15:0];
        e.c = (sum >= 65536);
      end
      e.z = (res == 16'd0);
      e.we = 1'b1;
      e.waddr = (op == 4'd1) ? ins[8:6] : ins[5:3];
      e.wdata = res;
      ref_rf[e.waddr] = res;
      ref_c = e.c;
      ref_z = e.z;
    end
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    ref_rf[a] = d;
  endtask

  // Offer one instruction, wait for acceptance, then watch until done (bounded).
  task automatic issue(input logic [15:0] ins, output obs_t o);
    int waited;
    o.lat = 0; o.we_cnt = 0; o.ill = 0; o.skip = 0; o.we = 0;
    o.waddr = 0; o.wdata = 0; o.c = 0; o.z = 0; o.rdy = 0;
    waited = 0;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", {31'd0, instr_ready}, 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) instr_valid = 1'b0;
      if (rf_we) o.we_cnt++;
      if (done) begin
        o.lat = c; o.ill = illegal; o.skip = skipped; o.we = rf_we;
        o.waddr = rf_waddr; o.wdata = rf_wdata; o.c = flag_c; o.z = flag_z;
        break;
      end
    end
    instr_valid = 1'b0;
    @(negedge clk);
    if (rf_we) o.we_cnt++;
    o.rdy = instr_ready;
  endtask

  task automatic cmp(input string tag, input obs_t o, input exp_t e);
    chk({tag, ".latency"}, o.lat, e.lat);
    chk({tag, ".illegal"}, {31'd0, o.ill}, {31'd0, e.ill});
    chk({tag, ".skipped"}, {31'd0, o.skip}, {31'd0, e.skip});
    chk({tag, ".rf_we"}, {31'd0, o.we}, {31'd0, e.we});
    chk({tag, ".we_pulses"}, o.we_cnt, {31'd0, e.we});
    if (e.we) begin
      chk({tag, ".waddr"}, {29'd0, o.waddr}, {29'd0, e.waddr});
      chk({tag, ".wdata"}, {16'd0, o.wdata}, {16'd0, e.wdata});
    end
    chk({tag, ".flag_c"}, {31'd0, o.c}, {31'd0, e.c});
    chk({tag, ".flag_z"}, {31'd0, o.z}, {31'd0, e.z});
    chk({tag, ".ready_after"}, {31'd0, o.rdy}, 32'd1);
  endtask

  vec_t tbl[13];

  initial begin
    obs_t        o;
    exp_t        e, ea, eb;
    logic [15:0] ia, ib;
    int          we_cnt, done_cnt;

    for (int i = 0; i < 8; i++) begin
      rf[i] = 16'(i * 16'h1111);
      ref_rf[i] = 16'(i * 16'h1111);
    end

    tbl[0]  = '{enc(4'd0, 3'd1, 3'd2, 3'd5, 2'd1), 1'b1, 16'h0005, 16'h0007, mk(3, 0, 1, 0, 3'd0, 16'h0000, 0, 0)};
    tbl[1]  = '{enc(4'd0, 3'd1, 3'd2, 3'd3, 2'd0), 1'b1, 16'hFFFF, 16'h0001, mk(3, 0, 0, 1, 3'd3, 16'h0000, 1, 1)};
    tbl[2]  = '{enc(4'd0, 3'd1, 3'd2, 3'd5, 2'd1), 1'b1, 16'h0005, 16'h0007, mk(3, 0, 0, 1, 3'd5, 16'h000C, 0, 0)};
    tbl[3]  = '{enc_adi(3'd1, 3'd2, 6'b111110),    1'b1, 16'h0010, 16'h1234, mk(3, 0, 0, 1, 3'd2, 16'h000E, 1, 0)};
    tbl[4]  = '{enc(4'd2, 3'd1, 3'd2, 3'd4, 2'd0), 1'b1, 16'hFFFF, 16'hFFFF, mk(3, 0, 0, 1, 3'd4, 16'h0000, 1, 1)};
    tbl[5]  = '{enc(4'd0, 3'd1, 3'd2, 3'd6, 2'd2), 1'b1, 16'h0003, 16'h0004, mk(3, 0, 0, 1, 3'd6, 16'h0007, 0, 0)};
    tbl[6]  = '{enc(4'd0, 3'd1, 3'd2, 3'd6, 2'd2), 1'b1, 16'h0003, 16'h0004, mk(3, 0, 1, 0, 3'd0, 16'h0000, 0, 0)};
    tbl[7]  = '{enc(4'd7, 3'd1, 3'd2, 3'd3, 2'd0), 1'b0, 16'h0000, 16'h0000, mk(1, 1, 0, 0, 3'd0, 16'h0000, 0, 0)};
    tbl[8]  = '{enc(4'd0, 3'd1, 3'd2, 3'd3, 2'd3), 1'b0, 16'h0000, 16'h0000, mk(1, 1, 0, 0, 3'd0, 16'h0000, 0, 0)};
    tbl[9]  = '{enc(4'd2, 3'd1, 3'd2, 3'd3, 2'd1), 1'b0, 16'h0000, 16'h0000, mk(3, 0, 1, 0, 3'd0, 16'h0000, 0, 0)};
    tbl[10] = '{enc(4'd0, 3'd1, 3'd2, 3'd0, 2'd0), 1'b1, 16'h0001, 16'h0001, mk(3, 0, 0, 1, 3'd0, 16'h0002, 0, 0)};
    tbl[11] = '{enc_adi(3'd3, 3'd7, 6'd5),         1'b1, 16'h7FFF, 16'h0000, mk(3, 0, 0, 1, 3'd7, 16'h8004, 0, 0)};
    tbl[12] = '{enc(4'd2, 3'd4, 3'd5, 3'd6, 2'd0), 1'b1, 16'h0F0F, 16'h00FF, mk(3, 0, 0, 1, 3'd6, 16'hFFF0, 0, 0)};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.done_we_skip_ill", {28'd0, done, rf_we, skipped, illegal}, 32'd0);
    chk("rst.flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("rst.alu", {alu_a, alu_b} | {31'd0, alu_op}, 32'd0);
    chk("rst.rf_w", {13'd0, rf_waddr, rf_wdata}, 32'd0);
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // vector table
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].preset) begin
        set_reg(tbl[i].ins[11:9], tbl[i].ra_v);
        set_reg(tbl[i].ins[8:6], tbl[i].rb_v);
      end
      predict(tbl[i].ins, e);
      issue(tbl[i].ins, o);
      cmp($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // reset in the middle of EXEC, with both flags set beforehand
    set_reg(3'd1, 16'hFFFF);
    set_reg(3'd2, 16'h0001);
    ia = enc(4'd0, 3'd1, 3'd2, 3'd3, 2'd0);
    predict(ia, e);
    issue(ia, o);
    cmp("pre_reset_add", o, e);
    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0006);
    @(negedge clk);
    instr = enc(4'd0, 3'd1, 3'd2, 3'd3, 2'd0);
    instr_valid = 1'b1;
    chk("midrst.ready", {31'd0, instr_ready}, 32'd1);
    we_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.flags", {30'd0, flag_c, flag_z}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      we_cnt += int'(rf_we);
      done_cnt += int'(done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.ready_after", {31'd0, instr_ready}, 32'd1);
    repeat (4) begin
      we_cnt += int'(rf_we);
      done_cnt += int'(done);
      @(negedge clk);
    end
    chk("midrst.we_pulses", we_cnt, 0);
    chk("midrst.done_pulses", done_cnt, 0);
    chk("midrst.flags_after", {30'd0, flag_c, flag_z}, 32'd0);
    ref_c = 1'b0;
    ref_z = 1'b0;

    // back-to-back offers: second instruction waits for instr_ready
    set_reg(3'd1, 16'h0001);
    set_reg(3'd2, 16'h0002);
    ia = enc(4'd0, 3'd1, 3'd2, 3'd3, 2'd0);
    ib = enc(4'd0, 3'd3, 3'd1, 3'd4, 2'd0);
    predict(ia, ea);
    predict(ib, eb);
    @(negedge clk);
    instr = ia;
    instr_valid = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      done_cnt += int'(done);
      if (c == 1) instr = ib;
      if (c >= 1 && c <= 3) chk($sformatf("b2b.busy_c%0d", c), {31'd0, instr_ready}, 32'd0);
      if (c == 3) chk("b2b.a_done_wdata", {15'd0, done, rf_wdata}, {15'd0, 1'b1, ea.wdata});
      if (c == 4) chk("b2b.ready_c4", {31'd0, instr_ready}, 32'd1);
      if (c == 5) instr_valid = 1'b0;
      if (c == 7) chk("b2b.b_done_wb", {12'd0, done, rf_waddr, rf_wdata}, {12'd0, 1'b1, eb.waddr, eb.wdata});
    end
    chk("b2b.done_count", done_cnt, 2);

    // illegal followed immediately by a legal instruction
    ia = enc(4'd7, 3'd1, 3'd2, 3'd3, 2'd0);
    ib = enc(4'd0, 3'd1, 3'd2, 3'd5, 2'd0);
    predict(ia, ea);
    predict(ib, eb);
    @(negedge clk);
    instr = ia;
    instr_valid = 1'b1;
    done_cnt = 0;
    we_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      done_cnt += int'(done);
      we_cnt += int'(rf_we);
      if (c == 1) begin
        chk("ill2.done_ill_c1", {30'd0, done, illegal}, 32'd3);
        instr = ib;
      end
      if (c == 2) chk("ill2.ready_c2", {31'd0, instr_ready}, 32'd1);
      if (c == 3) instr_valid = 1'b0;
      if (c == 5) chk("ill2.b_done", {14'd0, done, illegal, rf_wdata}, {14'd0, 2'b10, eb.wdata});
    end
    chk("ill2.done_count", done_cnt, 2);
    chk("ill2.we_count", we_cnt, 1);

    // randomized instructions against the reference model
    for (int n = 0; n < 48; n++) begin
      int          k;
      logic [3:0]  op;
      logic [15:0] ins;
      k = $urandom_range(0, 9);
      if (k <= 3) op = 4'd0;
      else if (k <= 5) op = 4'd1;
      else if (k <= 7) op = 4'd2;
      else op = 4'($urandom_range(3, 15));
      ins = {op, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 1) == 1) begin
        set_reg(ins[11:9], ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
        set_reg(ins[8:6], 16'($urandom));
      end
      predict(ins, e);
      issue(ins, o);
      cmp($sformatf("rnd%0d", n), o, e);
    end

    for (int i = 0; i < 8; i++) chk($sformatf("final_rf%0d", i), {16'd0, rf[i]}, {16'd0, ref_rf[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
